// File: rtl/otter_dcache.sv
// otter_dcache: direct-mapped write-back/write-allocate data cache between the OTTER memory stage and data memory port.
// Latency (request in IDLE = cycle 0 to CPU_READY): hit 1, clean miss 4, dirty miss 8, uncached write 2, uncached read 3, misaligned 1.
// Backpressure: CPU holds its request until the one-cycle CPU_READY pulse; DCACHE_STATS_EN adds HIT_COUNT/MISS_COUNT outputs.
module otter_dcache #(
  parameter int          LINES   = 16,
  parameter logic [31:0] IO_BASE = 32'h11000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] CPU_ADDR,
  input  logic [31:0] CPU_DIN,
  input  logic        CPU_RE,
  input  logic        CPU_WE,
  input  logic [1:0]  CPU_SIZE,
  input  logic        CPU_SIGN,
  output logic [31:0] CPU_DOUT,
  output logic        CPU_READY,
  output logic        CPU_ERR,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic        MEM_WRITE2,
  output logic        MEM_READ2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2,
  input  logic [31:0] MEM_r0,
  input  logic [31:0] MEM_r1,
  input  logic [31:0] MEM_r2,
  input  logic [31:0] MEM_r3
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] HIT_COUNT,
  output logic [31:0] MISS_COUNT
`endif
);

  localparam int IDXW = $clog2(LINES);
  localparam int TAGW = 28 - IDXW;

  typedef enum logic [2:0] {IDLE, WB, FILL, FILL_WAIT, UNC_RD, UNC_WAIT, UNC_WR, RESP} state_t;
  typedef logic [3:0][31:0] line_t;

  state_t           state_q, state_d;
  logic [LINES-1:0] valid_q, dirty_q;
  logic [TAGW-1:0]  tag_q  [LINES];
  line_t            data_q [LINES];
  logic [1:0]       wb_k_q;
  logic [31:0]      dout_q;
  logic             err_q;

  logic [IDXW-1:0]  idx;
  logic [TAGW-1:0]  req_tag;
  logic [1:0]       wsel;
  logic             req, misaligned, uncached, hit, victim_dirty, cached_hit;
  line_t            cur_line;

  assign idx          = CPU_ADDR[3+IDXW:4];
  assign req_tag      = CPU_ADDR[31:4+IDXW];
  assign wsel         = CPU_ADDR[3:2];
  assign req          = CPU_RE | CPU_WE;
  assign misaligned   = ((CPU_SIZE == 2'd1) & CPU_ADDR[0]) | (CPU_SIZE[1] & (CPU_ADDR[1:0] != 2'b00));
  assign uncached     = (CPU_ADDR >= IO_BASE);
  assign cur_line     = data_q[idx];
  assign hit          = valid_q[idx] & (tag_q[idx] == req_tag);
  assign victim_dirty = valid_q[idx] & dirty_q[idx];
  assign cached_hit   = req & ~misaligned & ~uncached & hit;
  assign CPU_DOUT     = dout_q;

  // Little-endian lane select; sign=1 means zero-extend.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] a,
                                               input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      2'd0:    load_extract = {(uns ? 24'h0 : {24{b[7]}}), b};
      2'd1:    load_extract = {(uns ? 16'h0 : {16{h[15]}}), h};
      default: load_extract = w;
    endcase
  endfunction

  // Merge right-aligned store data into the addressed lanes of a word.
  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] din,
                                              input logic [1:0] a, input logic [1:0] sz);
    logic [31:0] r;
    r = w;
    case (sz)
      2'd0:    r[{a, 3'b000} +: 8] = din[7:0];
      2'd1:    r = a[1] ? {din[15:0], w[15:0]} : {w[31:16], din[15:0]};
      default: r = din;
    endcase
    return r;
  endfunction

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: a completed fill returns to IDLE so the held request re-evaluates as a hit
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (misaligned)        state_d = RESP;
          else if (uncached)     state_d = CPU_WE ? UNC_WR : UNC_RD;
          else if (hit)          state_d = RESP;
          else if (victim_dirty) state_d = WB;
          else                   state_d = FILL;
        end
      end
      WB:        if (wb_k_q == 2'd3) state_d = FILL;
      FILL:      state_d = FILL_WAIT;
      FILL_WAIT: state_d = IDLE;
      UNC_RD:    state_d = UNC_WAIT;
      UNC_WAIT:  state_d = RESP;
      UNC_WR:    state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs: memory strobes only in WB/FILL/uncached states, idle defaults elsewhere
  always_comb begin
    MEM_ADDR2  = 32'h0;
    MEM_DIN2   = 32'h0;
    MEM_WRITE2 = 1'b0;
    MEM_READ2  = 1'b0;
    MEM_SIZE   = 2'd2;
    MEM_SIGN   = 1'b0;
    CPU_READY  = (state_q == RESP);
    CPU_ERR    = (state_q == RESP) & err_q;
    case (state_q)
      WB: begin
        MEM_WRITE2 = 1'b1;
        MEM_ADDR2  = {tag_q[idx], idx, wb_k_q, 2'b00};
        MEM_DIN2   = cur_line[wb_k_q];
      end
      FILL: begin
        MEM_READ2 = 1'b1;
        MEM_ADDR2 = {CPU_ADDR[31:4], 4'h0};
      end
      UNC_WR: begin
        MEM_WRITE2 = 1'b1;
        MEM_ADDR2  = CPU_ADDR;
        MEM_DIN2   = CPU_DIN;
        MEM_SIZE   = CPU_SIZE;
        MEM_SIGN   = CPU_SIGN;
      end
      UNC_RD: begin
        MEM_READ2 = 1'b1;
        MEM_ADDR2 = CPU_ADDR;
        MEM_SIZE  = CPU_SIZE;
        MEM_SIGN  = CPU_SIGN;
      end
      default: ;
    endcase
  end

  // Line status, writeback counter, load result and error flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0;
      dirty_q <= '0;
      wb_k_q  <= 2'd0;
      dout_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            err_q  <= misaligned;
            wb_k_q <= 2'd0;
            if (cached_hit) begin
              if (CPU_WE) dirty_q[idx] <= 1'b1;
              else        dout_q <= load_extract(cur_line[wsel], CPU_ADDR[1:0], CPU_SIZE, CPU_SIGN);
            end
          end
        end
        WB: begin
          wb_k_q <= wb_k_q + 2'd1;
          if (wb_k_q == 2'd3) dirty_q[idx] <= 1'b0;
        end
        FILL_WAIT: begin
          valid_q[idx] <= 1'b1;
          dirty_q[idx] <= 1'b0;
        end
        UNC_WAIT: dout_q <= MEM_DOUT2;
        default: ;
      endcase
    end
  end

  // Line data and tags: a fill replaces the line, a store hit merges into one word
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state_q == FILL_WAIT) begin
        data_q[idx] <= {MEM_r3, MEM_r2, MEM_r1, MEM_r0};
        tag_q[idx]  <= req_tag;
      end else if ((state_q == IDLE) && cached_hit && CPU_WE) begin
        data_q[idx][wsel] <= store_merge(cur_line[wsel], CPU_DIN, CPU_ADDR[1:0], CPU_SIZE);
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic refill_q;

  // Count each cached request once, skipping the re-evaluation that follows a fill
  always_ff @(posedge CLK) begin
    if (RST) begin
      HIT_COUNT  <= 32'h0;
      MISS_COUNT <= 32'h0;
      refill_q   <= 1'b0;
    end else begin
      if (state_q == FILL_WAIT) refill_q <= 1'b1;
      else if (state_q == IDLE) refill_q <= 1'b0;
      if ((state_q == IDLE) && req && !misaligned && !uncached && !refill_q) begin
        if (hit) begin
          if (HIT_COUNT != 32'hFFFFFFFF) HIT_COUNT <= HIT_COUNT + 32'd1;
        end else begin
          if (MISS_COUNT != 32'hFFFFFFFF) MISS_COUNT <= MISS_COUNT + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_otter_dcache.sv
// tb_otter_dcache: randomized scoreboard bench for otter_dcache against a flat-memory reference.
// Latency: responses and memory strobes are checked against expected cycle offsets from request issue.
// Backpressure: one outstanding request at a time, held until CPU_READY.
module tb_otter_dcache;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] CPU_ADDR, CPU_DIN, CPU_DOUT;
  logic        CPU_RE, CPU_WE, CPU_SIGN, CPU_READY, CPU_ERR;
  logic [1:0]  CPU_SIZE, MEM_SIZE;
  logic [31:0] MEM_ADDR2, MEM_DIN2, MEM_DOUT2, MEM_r0, MEM_r1, MEM_r2, MEM_r3;
  logic        MEM_WRITE2, MEM_READ2, MEM_SIGN;
`ifdef DCACHE_STATS_EN
  logic [31:0] HIT_COUNT, MISS_COUNT;
`endif

  otter_dcache dut (
    .CLK(CLK), .RST(RST),
    .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN), .CPU_RE(CPU_RE), .CPU_WE(CPU_WE),
    .CPU_SIZE(CPU_SIZE), .CPU_SIGN(CPU_SIGN), .CPU_DOUT(CPU_DOUT),
    .CPU_READY(CPU_READY), .CPU_ERR(CPU_ERR),
    .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2), .MEM_WRITE2(MEM_WRITE2),
    .MEM_READ2(MEM_READ2), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
    .MEM_DOUT2(MEM_DOUT2), .MEM_r0(MEM_r0), .MEM_r1(MEM_r1), .MEM_r2(MEM_r2), .MEM_r3(MEM_r3)
`ifdef DCACHE_STATS_EN
    , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = 32'h0;
  always @(posedge CLK) cyc <= cyc + 32'd1;

  // Byte stores: mem_b is the external memory, ref_b is what the CPU should observe.
  bit [7:0] mem_b [int unsigned];
  bit [7:0] ref_b [int unsigned];

  function automatic bit [7:0] init_byte(input logic [31:0] a);
    logic [31:0] t;
    t = a * 32'h9E3779B1 + 32'h1234567;
    return t[31:24];
  endfunction

  function automatic bit [7:0] get_b(input bit use_ref, input logic [31:0] a);
    if (use_ref) return ref_b.exists(a) ? ref_b[a] : init_byte(a);
    return mem_b.exists(a) ? mem_b[a] : init_byte(a);
  endfunction

  function automatic void put_b(input bit use_ref, input logic [31:0] a, input logic [7:0] d);
    if (use_ref) ref_b[a] = d;
    else         mem_b[a] = d;
  endfunction

  // sign=1 means unsigned, matching the OTTER memory convention
  function automatic logic [31:0] load_val(input bit use_ref, input logic [31:0] a,
                                           input logic [1:0] sz, input bit uns);
    logic [7:0] b0, b1;
    b0 = get_b(use_ref, a);
    b1 = get_b(use_ref, a + 32'd1);
    case (sz)
      2'd0:    return uns ? {24'h0, b0} : {{24{b0[7]}}, b0};
      2'd1:    return uns ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
      default: return {get_b(use_ref, a + 32'd3), get_b(use_ref, a + 32'd2), b1, b0};
    endcase
  endfunction

  function automatic void store_val(input bit use_ref, input logic [31:0] a,
                                    input logic [1:0] sz, input logic [31:0] d);
    put_b(use_ref, a, d[7:0]);
    if (sz >= 2'd1) put_b(use_ref, a + 32'd1, d[15:8]);
    if (sz >= 2'd2) begin
      put_b(use_ref, a + 32'd2, d[23:16]);
      put_b(use_ref, a + 32'd3, d[31:24]);
    end
  endfunction

  // External memory: writes land, read data appears for the following cycle.
  always @(negedge CLK) begin
    if (MEM_WRITE2 === 1'b1) store_val(1'b0, MEM_ADDR2, MEM_SIZE, MEM_DIN2);
    if (MEM_READ2 === 1'b1) begin
      MEM_r0    = load_val(1'b0, {MEM_ADDR2[31:4], 4'h0}, 2'd2, 1'b0);
      MEM_r1    = load_val(1'b0, {MEM_ADDR2[31:4], 4'h4}, 2'd2, 1'b0);
      MEM_r2    = load_val(1'b0, {MEM_ADDR2[31:4], 4'h8}, 2'd2, 1'b0);
      MEM_r3    = load_val(1'b0, {MEM_ADDR2[31:4], 4'hC}, 2'd2, 1'b0);
      MEM_DOUT2 = load_val(1'b0, MEM_ADDR2, MEM_SIZE, MEM_SIGN);
    end
  end

  typedef struct packed {
    logic [31:0] t0; logic [31:0] lat; logic err; logic chk; logic [31:0] dout; logic [15:0] id;
  } rsp_t;
  typedef struct packed {
    logic [31:0] cyc; logic wr; logic [31:0] addr; logic [31:0] data; logic [1:0] size; logic sign;
  } mev_t;
  rsp_t rsp_q[$];
  mev_t mev_q[$];
  logic [15:0] req_id = 16'h0;

  // Reference cache occupancy (16 lines, 16-byte lines) used only to predict latency and traffic.
  bit          mv [16];
  bit          md [16];
  logic [23:0] mt [16];
  int          hc = 0;
  int          mc = 0;

  function automatic void push_ev(input logic [31:0] c, input bit wr, input logic [31:0] a,
                                  input logic [31:0] d, input logic [1:0] sz, input bit sg);
    mev_t e;
    e.cyc = c; e.wr = wr; e.addr = a; e.data = d; e.size = sz; e.sign = sg;
    mev_q.push_back(e);
  endfunction

  function automatic void model_issue(input bit we, input logic [31:0] a, input logic [31:0] din,
                                      input logic [1:0] sz, input bit sg, input logic [31:0] t0);
    rsp_t r;
    int   i;
    bit   misal;
    logic [31:0] vb;
    r = '0; r.t0 = t0; r.id = req_id; req_id = req_id + 16'd1;
    misal = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    if (misal) begin
      r.lat = 1; r.err = 1'b1;
    end else if (a >= 32'h11000000) begin
      if (we) begin
        r.lat = 2; push_ev(t0 + 1, 1'b1, a, din, sz, sg); store_val(1'b1, a, sz, din);
      end else begin
        r.lat = 3; push_ev(t0 + 1, 1'b0, a, 32'h0, sz, sg);
        r.chk = 1'b1; r.dout = load_val(1'b1, a, sz, sg);
      end
    end else begin
      i = int'(a[7:4]);
      if (mv[i] && mt[i] == a[31:8]) begin
        r.lat = 1; hc++;
      end else begin
        mc++;
        if (mv[i] && md[i]) begin
          vb = {mt[i], a[7:4], 4'h0};
          for (int k = 0; k < 4; k++)
            push_ev(t0 + 1 + k, 1'b1, vb + 4 * k, load_val(1'b1, vb + 4 * k, 2'd2, 1'b0), 2'd2, 1'b0);
          push_ev(t0 + 5, 1'b0, {a[31:4], 4'h0}, 32'h0, 2'd2, 1'b0);
          r.lat = 8;
        end else begin
          push_ev(t0 + 1, 1'b0, {a[31:4], 4'h0}, 32'h0, 2'd2, 1'b0);
          r.lat = 4;
        end
        mv[i] = 1'b1; md[i] = 1'b0; mt[i] = a[31:8];
      end
      if (we) begin
        store_val(1'b1, a, sz, din); md[i] = 1'b1;
      end else begin
        r.chk = 1'b1; r.dout = load_val(1'b1, a, sz, sg);
      end
    end
    rsp_q.push_back(r);
  endfunction

  // Monitor: every memory strobe and every CPU_READY is matched against the scoreboard.
  mev_t ma, me;
  rsp_t re;
  always @(negedge CLK) begin
    if (MEM_WRITE2 === 1'b1 || MEM_READ2 === 1'b1) begin
      ma.cyc = cyc; ma.wr = MEM_WRITE2; ma.addr = MEM_ADDR2;
      ma.data = MEM_WRITE2 ? MEM_DIN2 : 32'h0; ma.size = MEM_SIZE; ma.sign = MEM_SIGN;
      checks++;
      if (mev_q.size() == 0) begin
        errors++;
        $display("FAIL mem_event unexpected: cyc %0d wr %0b addr %h data %h", cyc, ma.wr, ma.addr, ma.data);
      end else begin
        me = mev_q.pop_front();
        if (ma !== me) begin
          errors++;
          $display("FAIL mem_event: got cyc %0d wr %0b addr %h data %h size %0d sign %0b, expected cyc %0d wr %0b addr %h data %h size %0d sign %0b",
                   ma.cyc, ma.wr, ma.addr, ma.data, ma.size, ma.sign, me.cyc, me.wr, me.addr, me.data, me.size, me.sign);
        end
      end
    end
    if (CPU_READY === 1'b1) begin
      checks++;
      if (rsp_q.size() == 0) begin
        errors++;
        $display("FAIL response unexpected: cyc %0d dout %h err %b", cyc, CPU_DOUT, CPU_ERR);
      end else begin
        re = rsp_q.pop_front();
        if ((cyc - re.t0) != re.lat || CPU_ERR !== re.err || (re.chk && CPU_DOUT !== re.dout)) begin
          errors++;
          $display("FAIL response #%0d: got latency %0d err %b dout %h, expected latency %0d err %b dout %h",
                   re.id, cyc - re.t0, CPU_ERR, CPU_DOUT, re.lat, re.err, re.dout);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 16; i++) begin mv[i] = 1'b0; md[i] = 1'b0; mt[i] = 24'h0; end
    hc = 0; mc = 0;
  endtask

  // Issue one request at the start of an IDLE cycle; abort>0 pulses RST during that cycle offset.
  task automatic run_req(input bit we, input logic [31:0] a, input logic [31:0] din,
                         input logic [1:0] sz, input bit sg, input int abort);
    int n;
    model_issue(we, a, din, sz, sg, cyc);
    CPU_ADDR = a; CPU_DIN = din; CPU_SIZE = sz; CPU_SIGN = sg; CPU_WE = we; CPU_RE = !we;
    if (abort > 0) begin
      repeat (abort) begin @(posedge CLK); #1; end
      RST = 1'b1; CPU_RE = 1'b0; CPU_WE = 1'b0;
      @(posedge CLK); #1;
      RST = 1'b0;
      rsp_q.delete(); mev_q.delete(); reset_model();
      ref_b.delete();
      foreach (mem_b[k]) ref_b[k] = mem_b[k];
      @(negedge CLK);
      chk("abort_strobes", {28'h0, MEM_WRITE2, MEM_READ2, CPU_READY, CPU_ERR}, 32'h0);
      chk("abort_dout", CPU_DOUT, 32'h0);
      @(posedge CLK); #1;
    end else begin
      n = 0;
      do begin @(negedge CLK); n++; end while (CPU_READY !== 1'b1 && n < 40);
      if (CPU_READY !== 1'b1) begin
        checks++; errors++;
        $display("FAIL ready_timeout: addr %h no CPU_READY within %0d cycles", a, n);
        rsp_q.delete(); mev_q.delete();
      end
      @(posedge CLK); #1;
      CPU_RE = 1'b0; CPU_WE = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
    end
  endtask

  logic [31:0] ra, rd;
  logic [1:0]  rs;
  bit          rw, rg;

  initial begin
    RST = 1'b1; CPU_ADDR = 32'h0; CPU_DIN = 32'h0; CPU_RE = 1'b0; CPU_WE = 1'b0;
    CPU_SIZE = 2'd2; CPU_SIGN = 1'b0;
    MEM_DOUT2 = 32'h0; MEM_r0 = 32'h0; MEM_r1 = 32'h0; MEM_r2 = 32'h0; MEM_r3 = 32'h0;
    reset_model();
    store_val(1'b0, 32'h100, 2'd2, 32'hDEADBEEF);
    store_val(1'b1, 32'h100, 2'd2, 32'hDEADBEEF);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_strobes", {28'h0, MEM_WRITE2, MEM_READ2, CPU_READY, CPU_ERR}, 32'h0);
    chk("reset_dout", CPU_DOUT, 32'h0);
    chk("reset_mem_size", {30'h0, MEM_SIZE}, 32'd2);
    @(posedge CLK); #1;
    RST = 1'b0;

    // Directed sequence
    run_req(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 0);                 // cold miss
    run_req(1'b0, 32'h104, 32'h0, 2'd2, 1'b0, 0);                 // hit
    run_req(1'b0, 32'h103, 32'h0, 2'd0, 1'b0, 0);                 // lb
    run_req(1'b0, 32'h103, 32'h0, 2'd0, 1'b1, 0);                 // lbu
    run_req(1'b0, 32'h102, 32'h0, 2'd1, 1'b0, 0);                 // lh
    run_req(1'b1, 32'h101, 32'h55, 2'd0, 1'b0, 0);                // sb hit
    run_req(1'b0, 32'h1100, 32'h0, 2'd2, 1'b0, 0);                // dirty miss
    run_req(1'b1, 32'h11000000, 32'hA5, 2'd2, 1'b0, 0);           // uncached store
    run_req(1'b0, 32'h11000000, 32'h0, 2'd2, 1'b0, 0);            // uncached load
    run_req(1'b0, 32'h102, 32'h0, 2'd2, 1'b0, 0);                 // misaligned
    run_req(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 0);                 // evicted data came back

    // Random traffic over a few conflicting tags plus the IO window
    for (int it = 0; it < 300; it++) begin
      rw = 1'($urandom_range(0, 1));
      rg = 1'($urandom_range(0, 1));
      rs = 2'($urandom_range(0, 2));
      rd = $urandom;
      if ($urandom_range(0, 9) == 0) ra = 32'h11000000 + $urandom_range(0, 15);
      else ra = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
      run_req(rw, ra, rd, rs, rg, 0);
    end

    // Reset in the second writeback cycle, then a cold re-access
    run_req(1'b1, 32'h100, 32'h12345678, 2'd2, 1'b0, 0);
    run_req(1'b0, 32'h1100, 32'h0, 2'd2, 1'b0, 2);
    run_req(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 0);
    run_req(1'b0, 32'h104, 32'h0, 2'd2, 1'b0, 0);

    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk("rsp_queue_drained", rsp_q.size(), 32'd0);
    chk("mem_queue_drained", mev_q.size(), 32'd0);
`ifdef DCACHE_STATS_EN
    chk("hit_count", HIT_COUNT, hc);
    chk("miss_count", MISS_COUNT, mc);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/otter_dcache.md
Name: otter_dcache

Overview:
Direct-mapped, write-back, write-allocate data cache between the OTTER memory stage and the byte-addressable dual-port memory's data port.
- Services CPU loads and stores.
- Fills 16-byte lines through the memory's 4-word line read outputs (MEM_r0..MEM_r3, valid one cycle after MEM_READ2).
- Writes dirty lines back one word per cycle.
- Addresses at or above IO_BASE bypass the cache as single uncached accesses.

Parameters:
LINES, 16, number of lines (power of 2); index = ADDR[3+log2(LINES):4], tag = remaining upper bits.
IO_BASE, 32'h11000000, addresses >= this are uncached.

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
CPU_ADDR  in  32  byte address, held until CPU_READY
CPU_DIN  in  32  store data, right-aligned
CPU_RE  in  1  load request
CPU_WE  in  1  store request (RE and WE never both high)
CPU_SIZE  in  2  0=byte, 1=half, 2=word
CPU_SIGN  in  1  1=unsigned load
CPU_DOUT  out  32  load result, valid with CPU_READY
CPU_READY  out  1  one-cycle completion pulse
CPU_ERR  out  1  misaligned access, valid with CPU_READY
MEM_ADDR2  out  32  memory byte address
MEM_DIN2  out  32  memory write data
MEM_WRITE2  out  1  memory write strobe
MEM_READ2  out  1  memory read strobe
MEM_SIZE  out  2  access size to memory
MEM_SIGN  out  1  sign to memory
MEM_DOUT2  in  32  uncached read data, valid cycle after MEM_READ2
MEM_r0..MEM_r3  in  32 each  line words 0..3 (r0 = lowest address), valid cycle after MEM_READ2

Behaviour:
- Reset:
  - All valid and dirty bits cleared; state IDLE.
  - CPU_READY, CPU_ERR, MEM_WRITE2 and MEM_READ2 are 0; CPU_DOUT is 0.
  - Reset mid-writeback or mid-fill aborts immediately; a partially written line in memory is acceptable.
- States: IDLE, WB, FILL, FILL_WAIT, UNC_RD, UNC_WAIT, UNC_WR, RESP.
- IDLE transitions, when (RE|WE):
  - Misaligned (half with ADDR[0]=1, or word with ADDR[1:0]!=0) → RESP with CPU_ERR=1; no memory or cache change.
  - ADDR >= IO_BASE → UNC_RD or UNC_WR.
  - Hit: a load registers the extracted data; a store byte-merges into the line and sets dirty. Next state RESP.
  - Miss with victim valid and dirty → WB, counter k=0; otherwise → FILL.
- WB, k=0..3:
  - MEM_WRITE2=1, MEM_ADDR2 = victim line base + 4k, MEM_DIN2 = word k, MEM_SIZE=2.
  - After k=3, clear dirty → FILL.
- FILL: MEM_READ2=1, MEM_ADDR2 = request line base, MEM_SIZE=2 → FILL_WAIT.
- FILL_WAIT: capture MEM_r0..r3 into the line; set tag, valid=1, dirty=0 → IDLE. The request re-evaluates as a hit.
- Uncached paths:
  - UNC_WR: MEM_WRITE2=1 with the CPU address, data, size and sign passed through → RESP.
  - UNC_RD: MEM_READ2=1 → UNC_WAIT.
  - UNC_WAIT: CPU_DOUT <= MEM_DOUT2 → RESP.
- RESP: CPU_READY=1 for exactly one cycle → IDLE. The CPU changes or drops the request during RESP; new requests are sampled only in IDLE.
- Latency, with request first seen in IDLE at cycle 0 (READY cycle):
  - Hit: 1.
  - Clean miss: 4.
  - Dirty miss: 8.
  - Uncached write: 2.
  - Uncached read: 3.
- Load extraction by ADDR[1:0]:
  - Byte: sign- or zero-extended per CPU_SIGN.
  - Half from ADDR[1] lane.
  - Word: whole word.
- Store merge:
  - Byte writes DIN[7:0] into lane ADDR[1:0].
  - Half writes DIN[15:0] into half ADDR[1].
  - Word replaces the whole word.
- Memory port idle defaults outside WB/FILL/UNC states: MEM_WRITE2=0, MEM_READ2=0, MEM_SIZE=2, MEM_SIGN=0.

Optional Feature:
DCACHE_STATS_EN:
- When defined, adds 32-bit outputs HIT_COUNT and MISS_COUNT, cleared by RST.
- Each counts once per cached request as decided in IDLE on first evaluation. Post-fill re-evaluation does not count. Counters saturate at 32'hFFFFFFFF.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Cold lw 0x100 with memory word 0x100 = 0xDEADBEEF → MEM_READ2 with MEM_ADDR2=0x100 at cycle 1; CPU_READY at cycle 4 with CPU_DOUT=0xDEADBEEF. Then lw 0x104 → READY at cycle 1, no memory activity.
- After the fill: lb 0x103 → 0xFFFFFFDE; lbu 0x103 → 0x000000DE; lh 0x102 → 0xFFFFDEAD.
- sb 0x101 with DIN=0x55 (hit, READY at cycle 1), then lw 0x1100 (same index, different tag):
  - Four writes to 0x100/0x104/0x108/0x10C at cycles 1-4, first data 0xDEAD55EF.
  - Fill of 0x1100 at cycle 5; READY at cycle 8.
- sw 0x11000000 with DIN=0xA5 → single MEM_WRITE2 cycle with MEM_ADDR2=0x11000000; READY at cycle 2; no cache line changed.
- lw 0x102 → READY and CPU_ERR at cycle 1; MEM_READ2 and MEM_WRITE2 stay 0.
- RST asserted during the second WB cycle → next cycle state IDLE with all strobes 0. A re-issued lw 0x100 then misses as a cold access.
